// File: rtl/game_pkg.sv
// Shared types and constants for the dinosaur runner game sequencer.
package game_pkg;

    localparam int SPEED_W = 4;
    localparam int SCORE_W = 16;

    localparam logic [SCORE_W-1:0] BCD_ZERO = 16'h0000;

    // Encoding of game_status seen by the jump and ground blocks
    localparam logic GAME_STOP = 1'b0;
    localparam logic GAME_RUN  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    function automatic logic [SCORE_W-1:0] bcd_inc(
        input logic [SCORE_W-1:0] v
    );
        logic [SCORE_W-1:0] r;
        logic               c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < SCORE_W / 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up counter with a pulse on the 99->00 roll of the low digits.
module bcd_counter4
    import game_pkg::*;
(
    input  logic               CLK,
    input  logic               clrn,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] value,
    output logic               hundreds_carry
);

    assign hundreds_carry = inc & ~clear & (value[7:0] == 8'h99);

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            value <= BCD_ZERO;
        end else if (clear) begin
            value <= BCD_ZERO;
        end else if (inc) begin
            value <= bcd_inc(value);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: idle/run/dead FSM, BCD score, high score and buzzer.
module game_ctrl
    import game_pkg::*;
#(
    parameter int                 FRAMES_PER_POINT = 6,
    parameter logic [SPEED_W-1:0] SPEED_INIT       = 4'd2,
    parameter logic [SPEED_W-1:0] SPEED_MAX        = 4'd12,
    parameter int                 HOLD_FRAMES      = 60,
    parameter int                 BUZZ_FRAMES      = 20
) (
    input  logic               CLK,
    input  logic               clrn,
    input  logic               btn_jump,
    input  logic               vs,
    input  logic               collide,
    output logic               game_status,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               buzz
);

    localparam int FW = $clog2(FRAMES_PER_POINT + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = $clog2(BUZZ_FRAMES + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_POINT - 1);

    game_state_t state;

    logic btn_s1, btn_s2, btn_h;
    logic vs_s1, vs_s2, vs_h;
    logic start, tick;
    logic hit;

    logic [FW-1:0] frame_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] buzz_cnt;

    logic go, sc_inc, hc;

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_h  <= 1'b0;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_h   <= 1'b0;
        end else begin
            btn_s1 <= btn_jump;
            btn_s2 <= btn_s1;
            btn_h  <= btn_s2;
            vs_s1  <= vs;
            vs_s2  <= vs_s1;
            vs_h   <= vs_s2;
        end
    end

    assign start = btn_s2 & ~btn_h;
    assign tick  = vs_h & ~vs_s2;

    assign go = start & ((state == IDLE) |
                         ((state == DEAD) & (hold_cnt == '0)));

    assign sc_inc = (state == RUN) & tick & ~hit &
                    (frame_cnt == FRAME_LAST);

    bcd_counter4 u_score (
        .CLK           (CLK),
        .clrn          (clrn),
        .clear         (go),
        .inc           (sc_inc),
        .value         (score),
        .hundreds_carry(hc)
    );

    // A collide on the tick edge belongs to the next frame
    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            hit <= 1'b0;
        end else if (state != RUN) begin
            hit <= 1'b0;
        end else if (tick) begin
            hit <= collide;
        end else if (collide) begin
            hit <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            game_status <= GAME_STOP;
            speed       <= '0;
            hi_score    <= BCD_ZERO;
            buzz        <= 1'b0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            buzz_cnt    <= '0;
        end else if (go) begin
            state       <= RUN;
            game_status <= GAME_RUN;
            speed       <= SPEED_INIT;
            buzz        <= 1'b0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
            buzz_cnt    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (tick && hit) begin
                        state       <= DEAD;
                        game_status <= GAME_STOP;
                        buzz        <= 1'b1;
                        hold_cnt    <= HW'(HOLD_FRAMES);
                        buzz_cnt    <= BW'(BUZZ_FRAMES);
                        if (score > hi_score) begin
                            hi_score <= score;
                        end
                    end else if (tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                        if (hc && speed < SPEED_MAX) begin
                            speed <= speed + SPEED_W'(1);
                        end
                    end
                end
                DEAD: begin
                    if (tick) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                        if (buzz_cnt != '0) begin
                            buzz_cnt <= buzz_cnt - BW'(1);
                            if (buzz_cnt == BW'(1)) begin
                                buzz <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    game_status <= GAME_STOP;
                    speed       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: idle, scoring, speed, death, hold and reset.
module tb_game_ctrl;

    logic CLK = 1'b0;
    logic clrn;
    logic btn;
    logic btn2;
    logic vs;
    logic collide;

    logic        gs_m, gs_s, gs_w;
    logic [3:0]  sp_m, sp_s, sp_w;
    logic [15:0] sc_m, sc_s, sc_w;
    logic [15:0] hi_m, hi_s, hi_w;
    logic        bz_m, bz_s, bz_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    game_ctrl #(
        .FRAMES_PER_POINT(2),
        .SPEED_INIT      (4'd2),
        .SPEED_MAX       (4'd12),
        .HOLD_FRAMES     (3),
        .BUZZ_FRAMES     (2)
    ) u_main (
        .CLK        (CLK),
        .clrn       (clrn),
        .btn_jump   (btn),
        .vs         (vs),
        .collide    (collide),
        .game_status(gs_m),
        .speed      (sp_m),
        .score      (sc_m),
        .hi_score   (hi_m),
        .buzz       (bz_m)
    );

    game_ctrl #(
        .FRAMES_PER_POINT(1),
        .SPEED_INIT      (4'd11),
        .SPEED_MAX       (4'd12),
        .HOLD_FRAMES     (3),
        .BUZZ_FRAMES     (2)
    ) u_sat (
        .CLK        (CLK),
        .clrn       (clrn),
        .btn_jump   (btn2),
        .vs         (vs),
        .collide    (1'b0),
        .game_status(gs_s),
        .speed      (sp_s),
        .score      (sc_s),
        .hi_score   (hi_s),
        .buzz       (bz_s)
    );

    game_ctrl #(
        .FRAMES_PER_POINT(1),
        .SPEED_INIT      (4'd0),
        .SPEED_MAX       (4'd15),
        .HOLD_FRAMES     (3),
        .BUZZ_FRAMES     (2)
    ) u_wrap (
        .CLK        (CLK),
        .clrn       (clrn),
        .btn_jump   (btn2),
        .vs         (vs),
        .collide    (1'b0),
        .game_status(gs_w),
        .speed      (sp_w),
        .score      (sc_w),
        .hi_score   (hi_w),
        .buzz       (bz_w)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One vs low pulse; returns on the negedge after the frame update
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            @(negedge CLK);
            vs = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic press_main();
        btn = 1'b1;
        repeat (4) @(negedge CLK);
        btn = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic bump();
        collide = 1'b1;
        @(negedge CLK);
        collide = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn    = 1'b0;
        btn     = 1'b0;
        btn2    = 1'b0;
        vs      = 1'b1;
        collide = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_gs", 16'(gs_m), 16'h0);
        check("rst_speed", 16'(sp_m), 16'h0);
        check("rst_score", sc_m, 16'h0000);
        check("rst_hi", hi_m, 16'h0000);
        check("rst_buzz", 16'(bz_m), 16'h0);
        clrn = 1'b1;
        repeat (2) @(negedge CLK);

        frames(10);
        check("idle_gs", 16'(gs_m), 16'h0);
        check("idle_speed", 16'(sp_m), 16'h0);
        check("idle_score", sc_m, 16'h0000);
        check("idle_gs_sat", 16'(gs_s), 16'h0);

        btn = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("start_lat2", 16'(gs_m), 16'h0);
        @(posedge CLK);
        #1;
        check("start_lat3", 16'(gs_m), 16'h1);
        @(negedge CLK);
        @(negedge CLK);
        btn = 1'b0;
        repeat (3) @(negedge CLK);
        check("start_speed", 16'(sp_m), 16'h2);
        check("start_score", sc_m, 16'h0000);

        frames(20);
        check("run20_score", sc_m, 16'h0010);
        check("run20_speed", 16'(sp_m), 16'h2);

        frames(178);
        check("run99_score", sc_m, 16'h0099);
        check("run99_speed", 16'(sp_m), 16'h2);
        frames(2);
        check("run100_score", sc_m, 16'h0100);
        check("run100_speed", 16'(sp_m), 16'h3);
        frames(200);
        check("run200_score", sc_m, 16'h0200);
        check("run200_speed", 16'(sp_m), 16'h4);

        press_main();
        check("run_btn_gs", 16'(gs_m), 16'h1);
        check("run_btn_score", sc_m, 16'h0200);

        #1;
        clrn = 1'b0;
        #1;
        check("arst_gs", 16'(gs_m), 16'h0);
        check("arst_speed", 16'(sp_m), 16'h0);
        check("arst_score", sc_m, 16'h0000);
        check("arst_hi", hi_m, 16'h0000);
        check("arst_buzz", 16'(bz_m), 16'h0);
        @(negedge CLK);
        clrn = 1'b1;
        @(negedge CLK);

        press_main();
        frames(84);
        check("g1_42", sc_m, 16'h0042);
        frames(1);
        bump();
        frames(1);
        check("die_gs", 16'(gs_m), 16'h0);
        check("die_score", sc_m, 16'h0042);
        check("die_hi", hi_m, 16'h0042);
        check("die_buzz", 16'(bz_m), 16'h1);
        check("die_speed", 16'(sp_m), 16'h2);

        frames(1);
        check("dead_t1_buzz", 16'(bz_m), 16'h1);
        press_main();
        check("hold_btn_gs", 16'(gs_m), 16'h0);
        frames(1);
        check("dead_t2_buzz", 16'(bz_m), 16'h0);
        press_main();
        check("hold_btn2_gs", 16'(gs_m), 16'h0);
        frames(5);
        check("dead_frozen_score", sc_m, 16'h0042);
        press_main();
        check("restart_gs", 16'(gs_m), 16'h1);
        check("restart_score", sc_m, 16'h0000);
        check("restart_speed", 16'(sp_m), 16'h2);

        frames(60);
        check("g2_30", sc_m, 16'h0030);
        bump();
        frames(1);
        check("g2_gs", 16'(gs_m), 16'h0);
        check("g2_score", sc_m, 16'h0030);
        check("g2_hi", hi_m, 16'h0042);
        check("g2_buzz", 16'(bz_m), 16'h1);

        btn2 = 1'b1;
        repeat (4) @(negedge CLK);
        btn2 = 1'b0;
        repeat (3) @(negedge CLK);
        check("sat_gs", 16'(gs_s), 16'h1);
        check("sat_init", 16'(sp_s), 16'hb);
        frames(99);
        check("sat99_speed", 16'(sp_s), 16'hb);
        frames(1);
        check("sat100_score", sc_s, 16'h0100);
        check("sat100_speed", 16'(sp_s), 16'hc);
        frames(200);
        check("sat300_score", sc_s, 16'h0300);
        check("sat300_speed", 16'(sp_s), 16'hc);
        check("wrap300_speed", 16'(sp_w), 16'h3);

        frames(9699);
        check("wrap9999_score", sc_w, 16'h9999);
        check("wrap9999_speed", 16'(sp_w), 16'hf);
        frames(1);
        check("wrap0_score", sc_w, 16'h0000);
        check("wrap0_speed", 16'(sp_w), 16'hf);
        check("wrap0_sat_speed", 16'(sp_s), 16'hc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
